// File: rtl/fpga_ann_mac_pipe.sv
`timescale 1ns/1ps
// fpga_ann_mac_pipe
// Pipelined signed multiply-accumulate engine for ANN dot products.
// Operands are registered, multiplied through MUL_STAGES product stages,
// then summed per framed vector; the vector's last beat emits one result.
// One global enable stalls the whole pipeline when the output is blocked.
// Optional feature macro: FPGA_ANN_MAC_SAT_EN (saturating width reduction).
module fpga_ann_mac_pipe #(
    parameter int A_W        = 19,
    parameter int B_W        = 24,
    parameter int ACC_W      = 48,
    parameter int DOUT_W     = 40,
    parameter int MUL_STAGES = 2,
    parameter int FRAC_SHIFT = 0
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic signed [A_W-1:0]    din0,
    input  logic signed [B_W-1:0]    din1,
    input  logic                     in_last,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DOUT_W-1:0] dout,
    output logic                     out_sat,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int P_W = A_W + B_W;

    logic                    en;
    logic signed [A_W-1:0]   a_q;
    logic signed [B_W-1:0]   b_q;
    logic                    in_vld_q;
    logic                    in_last_q;
    logic signed [P_W-1:0]   a_ext;
    logic signed [P_W-1:0]   b_ext;
    logic signed [P_W-1:0]   product;
    logic signed [ACC_W-1:0] prod_q [MUL_STAGES];
    logic [MUL_STAGES-1:0]   vld_q;
    logic [MUL_STAGES-1:0]   last_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    first_q;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum;
    logic signed [DOUT_W-1:0] reduced;
    logic                    reduced_sat;

    // The pipeline only moves when the output register is free or being drained,
    // so a blocked result freezes every stage and no beat can be lost.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Full-width signed product; operands are sign-extended before multiplying.
    assign a_ext   = P_W'(a_q);
    assign b_ext   = P_W'(b_q);
    assign product = a_ext * b_ext;

    // Register the operands first so the multiplier sees clean inputs.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            a_q       <= '0;
            b_q       <= '0;
            in_vld_q  <= 1'b0;
            in_last_q <= 1'b0;
        end else if (en) begin
            a_q       <= din0;
            b_q       <= din1;
            in_vld_q  <= in_valid;
            in_last_q <= in_last;
        end
    end

    // Product delay line: each stage carries the product with its valid and last flags.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                prod_q[i] <= '0;
            end
            vld_q  <= '0;
            last_q <= '0;
        end else if (en) begin
            prod_q[0] <= ACC_W'(product);
            vld_q[0]  <= in_vld_q;
            last_q[0] <= in_last_q;
            for (int i = 1; i < MUL_STAGES; i++) begin
                prod_q[i] <= prod_q[i-1];
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
            end
        end
    end

    // Running sum; the first beat of a vector starts from zero instead of acc.
    always_comb begin
        base = acc_q;
        if (first_q) begin
            base = '0;
        end
        sum = base + prod_q[MUL_STAGES-1];
    end

`ifdef FPGA_ANN_MAC_SAT_EN
    logic signed [ACC_W-1:0] shifted;

    // Scale the sum and clip it to the output range, flagging any clipping.
    always_comb begin
        shifted     = sum >>> FRAC_SHIFT;
        reduced     = shifted[DOUT_W-1:0];
        reduced_sat = 1'b0;
        if (shifted[ACC_W-1:DOUT_W-1] != {(ACC_W-DOUT_W+1){shifted[ACC_W-1]}}) begin
            reduced_sat = 1'b1;
            if (shifted[ACC_W-1]) begin
                reduced = {1'b1, {(DOUT_W-1){1'b0}}};
            end else begin
                reduced = {1'b0, {(DOUT_W-1){1'b1}}};
            end
        end
    end
`else
    // Scale the sum and keep its low bits; overflow wraps in two's complement.
    always_comb begin
        reduced     = DOUT_W'(sum >>> FRAC_SHIFT);
        reduced_sat = 1'b0;
    end
`endif

    // Accumulate middle beats; on a last beat load the result and re-arm for a new vector.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            acc_q     <= '0;
            first_q   <= 1'b1;
            out_valid <= 1'b0;
            dout      <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            out_valid <= vld_q[MUL_STAGES-1] && last_q[MUL_STAGES-1];
            if (vld_q[MUL_STAGES-1]) begin
                if (last_q[MUL_STAGES-1]) begin
                    dout    <= reduced;
                    out_sat <= reduced_sat;
                    first_q <= 1'b1;
                end else begin
                    acc_q   <= sum;
                    first_q <= 1'b0;
                end
            end
        end
    end

endmodule
